// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b, LSB first), one full-subtractor cell plus one borrow flop.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+W; one op per W+2 cycles.
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped, not queued.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf and its MSB capture flops.

module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    // Counter only needs to reach W-1; W >= 2 keeps this at least one bit wide.
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_a_sh;
    logic [W-1:0]   r_b_sh;
    // Only W-1 partial bits are ever stored; the final bit goes straight into diff.
    logic [W-2:0]   r_res;
    logic           r_bw;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_diff;
    logic           r_borrow;

    logic           w_a0;
    logic           w_b0;
    logic           w_d;
    logic           w_bw_nxt;
    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_res_nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic           r_a_msb;
    logic           r_b_msb;
    logic           r_ovf;
`endif

    // Full-subtractor cell on the current LSBs and the borrow flop.
    assign w_a0      = r_a_sh[0];
    assign w_b0      = r_b_sh[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_bw;
    assign w_bw_nxt  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bw);

    // New difference bit enters at the MSB; after W shifts bit 0 of the result sits at bit 0.
    assign w_res_nxt = {w_d, r_res};

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_RUN) && (r_cnt == CW'(W - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE always returns to IDLE so a held start restarts every W+2 cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand capture and serial datapath; operands are frozen in the shifters so a/b may change freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_bw   <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_res  <= '0;
            r_bw   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_res  <= w_res_nxt[W-1:1];
            r_bw   <= w_bw_nxt;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Visible result only updates on the last bit, so partial results never leak onto diff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bw_nxt;
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep copies for the overflow decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[W-1];
            r_b_msb <= b[W-1];
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from the minuend's.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (W=8) with a result scoreboard.
// Expected results come from an arithmetic model pushed at stimulus time.
// Timing: inputs driven and outputs sampled on the falling clock edge.

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bw;
        logic         ov;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_diff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.bw = (x < y);
        e.ov = (x[W-1] ^ y[W-1]) & (x[W-1] ^ e.d[W-1]);
        return e;
    endfunction

    // Called in a cycle where done is high: pop the oldest expectation and compare.
    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_diff"},   32'(diff),   32'(e.d));
            chk({tag, "_borrow"}, 32'(borrow), 32'(e.bw));
`ifdef SERIAL_SUB_OVF_EN
            chk({tag, "_ovf"},    32'(ovf),    32'(e.ov));
`endif
            last_diff = e.d;
        end
    endtask

    // One operation; optionally changes a/b and pulses start mid-RUN.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit disturb);
        int cyc;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        sb.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        cyc = 0;
        while (done !== 1'b1 && cyc < 4 * W) begin
            if (disturb && cyc == 3) begin
                a = ~x; b = x; start = 1'b1;
            end else if (disturb && cyc == 4) begin
                start = 1'b0;
            end
            if (cyc == W / 2) chk({tag, "_hold_in_run"}, 32'(diff), 32'(last_diff));
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(W));
        if (done === 1'b1) check_done(tag);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'(0));
    endtask

    initial begin
        int nd;
        int cyc;
        int t1;
        int t2;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        last_diff = '0;
        t1 = 0; t2 = 0;
        #1;
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_done",   32'(done),   32'(0));
        chk("rst_diff",   32'(diff),   32'(0));
        chk("rst_borrow", 32'(borrow), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("sub_35_12", 8'h35, 8'h12, 1'b0);
        chk("sub_35_12_const", 32'(diff), 32'h23);
        run_op("sub_12_35", 8'h12, 8'h35, 1'b0);
        chk("sub_12_35_const", 32'({borrow, diff}), 32'h1DD);
        run_op("sub_00_01", 8'h00, 8'h01, 1'b0);
        chk("wrap_const", 32'({borrow, diff}), 32'h1FF);
        run_op("sub_aa_aa", 8'hAA, 8'hAA, 1'b0);
        chk("equal_const", 32'({borrow, diff}), 32'h000);

        // start and operand changes while running are ignored
        run_op("ignore_start", 8'h10, 8'h03, 1'b1);
        repeat (2) @(negedge clk);
        chk("no_restart_busy", 32'(busy), 32'(0));

        // reset in the middle of RUN (bit 4 about to be processed)
        @(negedge clk);
        a = 8'h5A; b = 8'h21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        chk("abort_busy",   32'(busy),   32'(0));
        chk("abort_done",   32'(done),   32'(0));
        chk("abort_diff",   32'(diff),   32'(0));
        chk("abort_borrow", 32'(borrow), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf",    32'(ovf),    32'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'(0));
        last_diff = '0;
        run_op("after_abort", 8'h5A, 8'h21, 1'b0);

        // signed overflow cases
        run_op("ovf_80_01", 8'h80, 8'h01, 1'b0);
        chk("ovf_80_01_const", 32'(diff), 32'h7F);
        run_op("ovf_05_03", 8'h05, 8'h03, 1'b0);
        chk("ovf_05_03_const", 32'(diff), 32'h02);

        // start held high: back-to-back operations every W+2 cycles
        @(negedge clk);
        a = 8'h44; b = 8'h45; start = 1'b1;
        sb.push_back(model(8'h44, 8'h45));
        sb.push_back(model(8'h44, 8'h45));
        nd = 0;
        cyc = 0;
        while (nd < 2 && cyc < 8 * W) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                nd++;
                check_done("held");
                if (nd == 1) begin
                    t1 = cyc;
                end else begin
                    t2 = cyc;
                    start = 1'b0;
                end
            end
        end
        chk("held_count",   32'(nd),      32'(2));
        chk("held_first",   32'(t1),      32'(W + 1));
        chk("held_spacing", 32'(t2 - t1), 32'(W + 2));
        repeat (3) @(negedge clk);
        chk("held_stopped", 32'(busy), 32'(0));

        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
